// File: rtl/cv32e40s_pkg.sv
`default_nettype none
// ============================================================================
// Package    : cv32e40s_pkg
// Description: Shared types for the instruction-side transaction path.
//              privlvl_t          - RISC-V privilege level encoding
//              obi_if_state_e     - address-phase holding FSM states
// Revision   : 1.0 - initial release
// ============================================================================
package cv32e40s_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } privlvl_t;

   // TRANSPARENT: OBI address phase driven straight from the requester.
   // REGISTERED : OBI address phase replayed from capture registers.
   typedef enum logic [0:0] {
      TRANSPARENT = 1'b0,
      REGISTERED  = 1'b1
   } obi_if_state_e;

endpackage : cv32e40s_pkg
`default_nettype wire

// File: rtl/cv32e40s_instr_trans_adapter.sv
`default_nettype none
// ============================================================================
// Module     : cv32e40s_instr_trans_adapter
// Description: Responder end of the prefetcher transaction interface. Issues
//              accepted fetch requests on the OBI instruction bus, holds the
//              OBI address phase stable until granted, limits the number of
//              outstanding transactions and passes responses straight back.
// Ports      :
//   clk, rst             - clock, synchronous active-high reset
//   trans_valid_i/ready_o- request handshake
//   trans_addr_i         - fetch address (may change while unaccepted)
//   trans_priv_lvl_i     - privilege level of the request
//   resp_valid_o/rdata_o/err_o - response passthrough
//   instr_req_o/gnt_i    - OBI address-phase handshake
//   instr_addr_o/prot_o  - OBI address phase (word aligned, {priv,0})
//   instr_rvalid_i/rdata_i/err_i - OBI response phase
// Revision   : 1.0 - initial release
// ============================================================================
module cv32e40s_instr_trans_adapter
   import cv32e40s_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        trans_valid_i,
   output logic        trans_ready_o,
   input  logic [31:0] trans_addr_i,
   input  privlvl_t    trans_priv_lvl_i,

   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,

   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   output logic [2:0]  instr_prot_o,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i
);

   localparam int                 CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]   C_MAX   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
   localparam logic [2:0]         C_PROT_RST = {PRIV_LVL_M, 1'b0};

   obi_if_state_e    r_state;
   obi_if_state_e    w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_addr;
   logic [2:0]       r_prot;

   logic             w_transparent;
   logic [CNT_W-1:0] w_cnt_eff;
   logic             w_handshake;
   logic             w_dec;
   logic [31:0]      w_addr_direct;
   logic [2:0]       w_prot_direct;

   assign w_addr_direct = {trans_addr_i[31:2], 2'b00};
   assign w_prot_direct = {trans_priv_lvl_i, 1'b0};

   // While reset is asserted the outputs already behave as if the FSM and
   // counter were cleared, so the requester sees a ready, transparent port.
   assign w_transparent = rst || (r_state == TRANSPARENT);
   assign w_cnt_eff     = rst ? '0 : r_cnt;

   always_comb begin
      trans_ready_o = 1'b0;
      instr_req_o   = 1'b1;
      instr_addr_o  = r_addr;
      instr_prot_o  = r_prot;
      if (w_transparent) begin
         trans_ready_o = (w_cnt_eff < C_MAX);
         instr_req_o   = trans_valid_i && trans_ready_o;
         instr_addr_o  = w_addr_direct;
         instr_prot_o  = w_prot_direct;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TRANSPARENT: if (instr_req_o && !instr_gnt_i) w_state_nxt = REGISTERED;
         REGISTERED:  if (instr_gnt_i)                 w_state_nxt = TRANSPARENT;
         default:                                      w_state_nxt = TRANSPARENT;
      endcase
   end

   assign w_handshake = trans_valid_i && trans_ready_o;
   // An rvalid with nothing outstanding is a protocol violation; ignore it so
   // the counter cannot wrap.
   assign w_dec       = instr_rvalid_i && (r_cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TRANSPARENT;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_prot  <= C_PROT_RST;
      end else begin
         r_state <= w_state_nxt;
         if (w_handshake && !w_dec) begin
            r_cnt <= r_cnt + C_ONE;
         end else if (w_dec && !w_handshake) begin
            r_cnt <= r_cnt - C_ONE;
         end
         // Capture the address phase the first cycle it goes ungranted.
         if ((r_state == TRANSPARENT) && instr_req_o && !instr_gnt_i) begin
            r_addr <= w_addr_direct;
            r_prot <= w_prot_direct;
         end
      end
   end

   assign resp_valid_o = instr_rvalid_i;
   assign resp_rdata_o = instr_rdata_i;
   assign resp_err_o   = instr_err_i;

endmodule : cv32e40s_instr_trans_adapter
`default_nettype wire
